// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM-stage access controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int TIMEOUT_CYC_DEF = 16;
  localparam int CNT_W_DEF       = $clog2(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without an acknowledge; expired_o flags the last allowed cycle.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter: clear dominates, saturates at the expiry value
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable_i && !expired_o) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired_o = (cnt_r == CNT_MAX);

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: runs loads/stores over a req/ack memory port, stalls the
// front of the pipe while busy and passes non-memory instructions straight through.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_valid_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] Result_i,
  input  logic [DATA_W-1:0] WData_i,
  input  logic [REG_AW-1:0] RD_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              wb_valid_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] Result_o,
  output logic [DATA_W-1:0] Data_o,
  output logic [REG_AW-1:0] RD_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  state_e state_r;
  state_e state_n_s;

  logic              mem_op_s;
  logic              misaligned_s;
  logic              latch_s;
  logic              expired_s;
  logic              ctr_clear_s;
  logic              ctr_en_s;

  logic              regwrite_r;
  logic              memtoreg_r;
  logic              memread_r;
  logic              memwrite_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic [REG_AW-1:0] rd_r;

  assign mem_op_s     = ex_valid_i & (MemRead_i | MemWrite_i);
  assign misaligned_s = mem_op_s & (Result_i[1:0] != 2'b00);
  assign latch_s      = (state_r == ST_IDLE) & mem_op_s & ~misaligned_s;
  assign ctr_clear_s  = (state_r != ST_BUSY);
  assign ctr_en_s     = (state_r == ST_BUSY) & ~mem_ack_i;

  mem_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (ctr_clear_s),
    .enable_i  (ctr_en_s),
    .expired_o (expired_s)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Latched instruction and returned load data; a timeout cancels the writeback
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      regwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
      addr_r     <= {DATA_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      rdata_r    <= {DATA_W{1'b0}};
      rd_r       <= {REG_AW{1'b0}};
    end else if (latch_s) begin
      regwrite_r <= RegWrite_i;
      memtoreg_r <= MemtoReg_i;
      memread_r  <= MemRead_i;
      memwrite_r <= MemWrite_i;
      addr_r     <= Result_i;
      wdata_r    <= WData_i;
      rdata_r    <= {DATA_W{1'b0}};
      rd_r       <= RD_i;
    end else if (state_r == ST_BUSY) begin
      if (mem_ack_i) begin
        if (memread_r) begin
          rdata_r <= mem_rdata_i;
        end
      end else if (expired_s) begin
        regwrite_r <= 1'b0;
      end
    end
  end

  // Next state and all outputs; everything is held at zero while in reset
  always_comb begin
    state_n_s   = state_r;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {DATA_W{1'b0}};
    mem_wdata_o = {DATA_W{1'b0}};
    wb_valid_o  = 1'b0;
    RegWrite_o  = 1'b0;
    MemtoReg_o  = 1'b0;
    Result_o    = {DATA_W{1'b0}};
    Data_o      = {DATA_W{1'b0}};
    RD_o        = {REG_AW{1'b0}};
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    if (!rst_n_i) begin
      state_n_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (latch_s) begin
            state_n_s = ST_BUSY;
            stall_o   = 1'b1;
          end else begin
            state_n_s  = ST_IDLE;
            wb_valid_o = ex_valid_i;
            RegWrite_o = RegWrite_i & ~misaligned_s;
            MemtoReg_o = MemtoReg_i;
            Result_o   = Result_i;
            RD_o       = RD_i;
            misalign_o = misaligned_s;
          end
        end
        ST_BUSY: begin
          stall_o     = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = memwrite_r;
          mem_addr_o  = addr_r;
          mem_wdata_o = wdata_r;
          // An ack in the expiry cycle still completes the access cleanly
          if (mem_ack_i) begin
            state_n_s = ST_DONE;
          end else if (expired_s) begin
            state_n_s = ST_DONE;
            bus_err_o = 1'b1;
          end else begin
            state_n_s = ST_BUSY;
          end
        end
        ST_DONE: begin
          state_n_s  = ST_IDLE;
          wb_valid_o = 1'b1;
          RegWrite_o = regwrite_r;
          MemtoReg_o = memtoreg_r;
          Result_o   = addr_r;
          Data_o     = rdata_r;
          RD_o       = rd_r;
        end
        default: begin
          state_n_s = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage: a transaction-level model predicts every
// cycle's outputs, a negedge process compares, and directed cases pin the model.
module tb_mem_access_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          ex_valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [DW-1:0] Result_i, WData_i;
  logic [AW-1:0] RD_i;
  logic          stall_o, mem_req_o, mem_we_o;
  logic [DW-1:0] mem_addr_o, mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          wb_valid_o, RegWrite_o, MemtoReg_o;
  logic [DW-1:0] Result_o, Data_o;
  logic [AW-1:0] RD_o;
  logic          misalign_o, bus_err_o;

  mem_access_stage #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ex_valid_i(ex_valid_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .Result_i(Result_i), .WData_i(WData_i), .RD_i(RD_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o), .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o), .Result_o(Result_o), .Data_o(Data_o), .RD_o(RD_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          valid;
    logic          rw;
    logic          m2r;
    logic          mr;
    logic          mw;
    logic [DW-1:0] res;
    logic [DW-1:0] wd;
    logic [AW-1:0] rd;
  } instr_t;

  int checks   = 0;
  int failures = 0;

  // expected values for the current cycle, written by the driver
  logic          e_chk = 1'b0, e_zero, e_pay, e_chkdata;
  logic          e_stall, e_valid, e_req, e_we, e_mis, e_berr, e_rw, e_m2r;
  logic [DW-1:0] e_addr, e_wdata, e_res, e_data;
  logic [AW-1:0] e_rd;

  // observations accumulated by step() for the literal pins
  int            obs_stall, obs_req, obs_mis, obs_berr, obs_valid;
  logic [DW-1:0] last_data, last_res;
  logic          last_rw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (e_chk) begin
      chk("stall", stall_o, e_stall);
      chk("wb_valid", wb_valid_o, e_valid);
      chk("mem_req", mem_req_o, e_req);
      chk("misalign", misalign_o, e_mis);
      chk("bus_err", bus_err_o, e_berr);
      if (e_req) begin
        chk("mem_we", mem_we_o, e_we);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, e_wdata);
      end
      if (e_pay) begin
        chk("RegWrite", RegWrite_o, e_rw);
        chk("MemtoReg", MemtoReg_o, e_m2r);
        chk("Result", Result_o, e_res);
        chk("RD", RD_o, e_rd);
      end
      if (e_chkdata) chk("Data", Data_o, e_data);
      if (e_zero) begin
        chk("reset_outputs_zero", 32'(|{stall_o, mem_req_o, mem_we_o, mem_addr_o,
            mem_wdata_o, wb_valid_o, RegWrite_o, MemtoReg_o, Result_o, Data_o, RD_o,
            misalign_o, bus_err_o}), 32'd0);
      end
    end
  end

  function automatic instr_t mk(input logic v, input logic rw, input logic m2r,
                                input logic mr, input logic mw, input logic [DW-1:0] res,
                                input logic [DW-1:0] wd, input logic [AW-1:0] rd);
    instr_t i;
    i.valid = v; i.rw = rw; i.m2r = m2r; i.mr = mr; i.mw = mw;
    i.res = res; i.wd = wd; i.rd = rd;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ex_valid_i = i.valid; RegWrite_i = i.rw; MemtoReg_i = i.m2r;
    MemRead_i  = i.mr;    MemWrite_i = i.mw; Result_i   = i.res;
    WData_i    = i.wd;    RD_i       = i.rd;
  endtask

  task automatic scramble();
    drive(mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, 5'($urandom)));
  endtask

  task automatic clr_exp();
    e_chk = 1'b1; e_zero = 1'b0; e_pay = 1'b0; e_chkdata = 1'b0;
    e_stall = 1'b0; e_valid = 1'b0; e_req = 1'b0; e_we = 1'b0; e_mis = 1'b0;
    e_berr = 1'b0; e_rw = 1'b0; e_m2r = 1'b0;
    e_addr = 32'd0; e_wdata = 32'd0; e_res = 32'd0; e_data = 32'd0; e_rd = 5'd0;
  endtask

  task automatic clr_obs();
    obs_stall = 0; obs_req = 0; obs_mis = 0; obs_berr = 0; obs_valid = 0;
    last_data = 32'd0; last_res = 32'd0; last_rw = 1'b0;
  endtask

  // called 1 time unit after a posedge; samples at the negedge, returns after the next posedge
  task automatic step();
    #4;
    obs_stall += int'(stall_o);
    obs_req   += int'(mem_req_o);
    obs_mis   += int'(misalign_o);
    obs_berr  += int'(bus_err_o);
    if (wb_valid_o) begin
      obs_valid++;
      last_data = Data_o; last_res = Result_o; last_rw = RegWrite_o;
    end
    @(posedge clk_i);
    #1;
  endtask

  // One instruction from EX/MEM until the pipe advances. ack_at: BUSY cycle
  // (1-based) in which memory acknowledges; 0 or beyond the timeout means never.
  task automatic run_instr(input instr_t ins, input int ack_at, input logic [DW-1:0] rdata);
    logic mem, tout;
    int   n;
    mem = ins.valid && (ins.mr || ins.mw);
    drive(ins);
    mem_ack_i = 1'($urandom);
    mem_rdata_i = $urandom;
    clr_exp();
    if (!mem || ins.res[1:0] != 2'b00) begin
      e_valid = ins.valid; e_pay = 1'b1; e_chkdata = 1'b1; e_data = 32'd0;
      e_rw = ins.rw && !mem; e_m2r = ins.m2r; e_res = ins.res; e_rd = ins.rd;
      e_mis = mem;
      step();
    end else begin
      e_stall = 1'b1;
      step();
      tout = (ack_at == 0) || (ack_at > TO);
      n = tout ? TO : ack_at;
      for (int k = 1; k <= n; k++) begin
        scramble();
        mem_ack_i = (k == ack_at);
        mem_rdata_i = (k == ack_at) ? rdata : $urandom;
        clr_exp();
        e_stall = 1'b1; e_req = 1'b1; e_we = ins.mw; e_addr = ins.res; e_wdata = ins.wd;
        e_berr = tout && (k == TO);
        step();
      end
      scramble();
      mem_ack_i = 1'($urandom);
      mem_rdata_i = $urandom;
      clr_exp();
      e_valid = 1'b1; e_pay = 1'b1;
      e_rw = ins.rw && !tout; e_m2r = ins.m2r; e_res = ins.res; e_rd = ins.rd;
      e_chkdata = ins.mr && !tout; e_data = rdata;
      step();
    end
  endtask

  initial begin
    instr_t ins;
    int     op, ack_at;
    rst_n_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'd0;
    scramble();
    clr_obs();
    clr_exp();
    e_zero = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      scramble();
      mem_ack_i = 1'($urandom);
      clr_exp(); e_zero = 1'b1;
      step();
    end
    rst_n_i = 1'b1;

    // ALU pass-through
    clr_obs();
    run_instr(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5), 0, 32'd0);
    chk("alu_stall_cycles", obs_stall, 32'd0);
    chk("alu_valid_cycles", obs_valid, 32'd1);
    chk("alu_result", last_res, 32'h1234);
    chk("alu_regwrite", last_rw, 32'd1);

    // load, ack in first BUSY cycle
    clr_obs();
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7), 1, 32'hDEADBEEF);
    chk("lw_stall_cycles", obs_stall, 32'd2);
    chk("lw_req_cycles", obs_req, 32'd1);
    chk("lw_data", last_data, 32'hDEADBEEF);

    // store, ack after 4 BUSY cycles
    clr_obs();
    run_instr(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd0), 4, 32'd0);
    chk("sw_req_cycles", obs_req, 32'd4);
    chk("sw_stall_cycles", obs_stall, 32'd5);

    // misaligned load
    clr_obs();
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd3), 1, 32'd0);
    chk("mis_pulses", obs_mis, 32'd1);
    chk("mis_req_cycles", obs_req, 32'd0);
    chk("mis_stall_cycles", obs_stall, 32'd0);
    chk("mis_regwrite", last_rw, 32'd0);

    // load never acknowledged
    clr_obs();
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd9), 0, 32'd0);
    chk("tmo_req_cycles", obs_req, 32'd16);
    chk("tmo_bus_err_pulses", obs_berr, 32'd1);
    chk("tmo_regwrite", last_rw, 32'd0);

    // ack in the expiry cycle wins over the timeout
    clr_obs();
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 5'd10), 16, 32'h0BADF00D);
    chk("edge_bus_err_pulses", obs_berr, 32'd0);
    chk("edge_data", last_data, 32'h0BADF00D);
    chk("edge_regwrite", last_rw, 32'd1);

    // reset in BUSY cycle 2
    drive(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd4));
    mem_ack_i = 1'b0;
    clr_exp(); e_stall = 1'b1;
    step();
    clr_exp(); e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h100;
    step();
    rst_n_i = 1'b0;
    clr_exp(); e_zero = 1'b1;
    step();
    rst_n_i = 1'b1;
    clr_obs();
    run_instr(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd6), 0, 32'd0);
    chk("post_reset_req_cycles", obs_req, 32'd0);
    chk("post_reset_stall_cycles", obs_stall, 32'd0);
    chk("post_reset_valid_cycles", obs_valid, 32'd1);
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 5'd4), 2, 32'h13572468);

    // randomised traffic
    for (int t = 0; t < 300; t++) begin
      op = $urandom_range(0, 3);
      ins = mk(op != 3, 1'($urandom), 1'($urandom), op == 1, op == 2,
               $urandom, $urandom, 5'($urandom));
      if ($urandom_range(0, 3) != 0) ins.res[1:0] = 2'b00;
      if (op == 3) begin
        ins.mr = 1'($urandom);
        ins.mw = 1'($urandom);
      end
      ack_at = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 18);
      run_instr(ins, ack_at, $urandom);
    end

    e_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
